apb_multi_requester: RTL and testbench

- Parametrised APB requester that bridges a simple host request port onto an APB bus with NUM_SLAVES completers.
- Next generation of the team's single-completer APB master. Adds width parameters, address-based PSELx decode, per-completer response muxing, a wait-state timeout, and back-to-back transfers without an IDLE bubble.
- Sits between the test/host logic and the APB completer fabric.

---
 rtl/apb_multi_requester.sv | 171 +++++++++++++++++
 tb/tb_apb_multi_requester.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_multi_requester.sv
// APB requester: host request port to an APB bus with NUM_SLAVES completers.
// Address-decoded PSELx, per-completer response mux, wait-state timeout, back-to-back transfers.
module apb_multi_requester #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                             PCLK,
  input  logic                             PRESET,
  input  logic                             transfer,
  output logic                             req_ready,
  input  logic                             write_en,
  input  logic [ADDR_WIDTH-1:0]            waddr,
  input  logic [DATA_WIDTH-1:0]            wdata,
  input  logic [DATA_WIDTH/8-1:0]          strb,
  input  logic [2:0]                       prot,
  input  logic                             pnse,
  output logic                             done,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic                             error,
  output logic                             timeout,
  output logic [NUM_SLAVES-1:0]            PSELx,
  output logic                             PENABLE,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic                             PWRITE,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic [DATA_WIDTH/8-1:0]          PSTRB,
  output logic [2:0]                       PPROT,
  output logic                             PNSE,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]            PREADY,
  input  logic [NUM_SLAVES-1:0]            PSLVERR
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned SEL_BITS   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned SEL_W1     = SEL_BITS + 1;
  localparam int unsigned CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [SEL_BITS:0] NUM_SEL  = SEL_W1'(NUM_SLAVES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDecerr} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q, rdata_q, rdata_d, rdata_mux;
  logic [STRB_WIDTH-1:0]   strb_q;
  logic                    write_q, pnse_q;
  logic [2:0]              prot_q;
  logic [SEL_BITS-1:0]     idx_q, req_idx;
  logic [CNT_W-1:0]        wait_cnt_q;
  logic                    done_q, done_d, error_q, error_d, timeout_q, timeout_d;
  logic [NUM_SLAVES-1:0]   sel_oh;
  logic                    pready_sel, pslverr_sel, tmo_fire, ready_int, accept, legal;

  assign req_idx = waddr[ADDR_WIDTH-1 -: SEL_BITS];
  assign legal   = {1'b0, req_idx} < NUM_SEL;

  // Select and response mux driven only by the captured index.
  always_comb begin
    sel_oh    = '0;
    rdata_mux = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (idx_q == SEL_BITS'(k)) begin
        sel_oh[k] = 1'b1;
        rdata_mux = PRDATA[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign pready_sel  = |(PREADY & sel_oh);
  assign pslverr_sel = |(PSLVERR & sel_oh);
  assign tmo_fire    = (TIMEOUT != 0) && (state_q == StAccess) && !pready_sel &&
                       (wait_cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    ready_int = 1'b0;
    unique case (state_q)
      StIdle:   ready_int = 1'b1;
      StSetup:  state_d = StAccess;
      StAccess: begin
        if (pready_sel || tmo_fire) begin
          ready_int = 1'b1;
          state_d   = StIdle;
        end
      end
      StDecerr: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (ready_int && transfer) state_d = legal ? StSetup : StDecerr;
  end

  assign accept    = ready_int & transfer;
  assign req_ready = ready_int & ~PRESET;

  // PREADY has priority over a simultaneous timeout.
  always_comb begin
    done_d    = 1'b0;
    error_d   = 1'b0;
    timeout_d = 1'b0;
    rdata_d   = rdata_q;
    if (state_q == StAccess && pready_sel) begin
      done_d  = 1'b1;
      error_d = pslverr_sel;
      rdata_d = write_q ? '0 : rdata_mux;
    end else if (tmo_fire) begin
      done_d    = 1'b1;
      error_d   = 1'b1;
      timeout_d = 1'b1;
      rdata_d   = '0;
    end else if (state_q == StDecerr) begin
      done_d  = 1'b1;
      error_d = 1'b1;
      rdata_d = '0;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      write_q    <= 1'b0;
      prot_q     <= '0;
      pnse_q     <= 1'b0;
      idx_q      <= '0;
      wait_cnt_q <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      timeout_q  <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      error_q   <= error_d;
      timeout_q <= timeout_d;
      rdata_q   <= rdata_d;
      if (accept) begin
        addr_q  <= waddr;
        wdata_q <= wdata;
        strb_q  <= write_en ? strb : '0;
        write_q <= write_en;
        prot_q  <= prot;
        pnse_q  <= pnse;
        idx_q   <= req_idx;
      end
      if (state_q == StSetup) begin
        wait_cnt_q <= '0;
      end else if (state_q == StAccess && !pready_sel) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end
    end
  end

  assign PSELx   = (state_q == StSetup || state_q == StAccess) ? sel_oh : '0;
  assign PENABLE = (state_q == StAccess);
  assign PADDR   = addr_q;
  assign PWRITE  = write_q;
  assign PWDATA  = wdata_q;
  assign PSTRB   = strb_q;
  assign PPROT   = prot_q;
  assign PNSE    = pnse_q;
  assign done    = done_q;
  assign error   = error_q;
  assign timeout = timeout_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_apb_multi_requester.sv
// Scoreboard bench for apb_multi_requester: host driver, APB completer model, done monitor.
module tb_apb_multi_requester;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned NS  = 3;
  localparam int unsigned TMO = 16;
  localparam int unsigned SW  = DW / 8;

  logic             PCLK = 1'b0;
  logic             PRESET = 1'b1;
  logic             transfer, req_ready, write_en, pnse, done, error, timeout;
  logic [AW-1:0]    waddr, PADDR;
  logic [DW-1:0]    wdata, rdata, PWDATA;
  logic [SW-1:0]    strb, PSTRB;
  logic [2:0]       prot, PPROT;
  logic [NS-1:0]    PSELx, PREADY, PSLVERR;
  logic             PENABLE, PWRITE, PNSE;
  logic [NS*DW-1:0] PRDATA;

  apb_multi_requester #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .TIMEOUT(TMO)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .req_ready(req_ready),
    .write_en(write_en), .waddr(waddr), .wdata(wdata), .strb(strb), .prot(prot), .pnse(pnse),
    .done(done), .rdata(rdata), .error(error), .timeout(timeout), .PSELx(PSELx),
    .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PPROT(PPROT), .PNSE(PNSE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    logic [2:0]    prot;
    logic          pnse;
    int            waits;
    logic          slverr;
    logic [DW-1:0] rval;
  } bus_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          error;
    logic          tmo;
    int            cycle;
  } exp_t;

  bus_t bus_q[$];
  exp_t exp_q[$];
  int   npass = 0;
  int   ntot  = 0;
  int   cyc   = 0;

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] req);
    ntot++;
    if (ok) npass++;
    else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic int sel_of(input logic [AW-1:0] a);
    logic [1:0] i;
    i = a[AW-1 -: 2];
    return int'(i);
  endfunction

  // Reference: outcome and completion cycle from acceptance cycle c.
  function automatic exp_t model(input bus_t t, input int c);
    exp_t e;
    e.rdata = '0;
    e.error = 1'b1;
    e.tmo   = 1'b0;
    if (sel_of(t.addr) >= NS) begin
      e.cycle = c + 2;
    end else if (t.waits >= TMO) begin
      e.tmo   = 1'b1;
      e.cycle = c + 2 + TMO;
    end else begin
      e.rdata = t.write ? '0 : t.rval;
      e.error = t.slverr;
      e.cycle = c + 3 + t.waits;
    end
    return e;
  endfunction

  function automatic bus_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [SW-1:0] s, input int waits, input logic se,
                              input logic [DW-1:0] rv);
    bus_t t;
    t.write = w; t.addr = a; t.wdata = d; t.strb = s; t.waits = waits;
    t.slverr = se; t.rval = rv;
    t.prot = 3'($urandom); t.pnse = 1'($urandom);
    return t;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input bus_t t);
    bit acc;
    int c;
    transfer = 1'b1; write_en = t.write; waddr = t.addr; wdata = t.wdata;
    strb = t.strb; prot = t.prot; pnse = t.pnse;
    acc = 0;
    c = 0;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge PCLK);
      #2;
      acc = req_ready;
      c = cyc;
      @(posedge PCLK);
      #1;
    end
    transfer = 1'b0;
    if (!acc) begin
      check(1'b0, "accept_bound", 0, 1);
    end else begin
      if (sel_of(t.addr) < NS) bus_q.push_back(t);
      exp_q.push_back(model(t, c));
    end
  endtask

  task automatic idle(input int n);
    transfer = 1'b0;
    repeat (n) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  // Completer model: unselected lanes get noise, selected lane follows the descriptor.
  bus_t cur;
  bit   active = 0;
  int   nacc = 0;
  initial forever begin
    logic [NS*DW-1:0] rd;
    logic [NS-1:0]    rdy, err;
    int               k;
    @(negedge PCLK);
    for (int j = 0; j < NS; j++) rd[j*DW +: DW] = $urandom;
    rdy = NS'($urandom);
    err = NS'($urandom);
    if (PRESET) begin
      active = 0;
    end else if (|PSELx && !PENABLE) begin
      if (bus_q.size() == 0) begin
        check(1'b0, "unexpected_setup", 64'(PSELx), 0);
        active = 0;
      end else begin
        cur = bus_q.pop_front();
        active = 1;
        nacc = 0;
        k = sel_of(cur.addr);
        check(PSELx == (NS'(1) << k), "setup_psel", 64'(PSELx), 64'(NS'(1) << k));
        check(PADDR == cur.addr && PWDATA == cur.wdata, "setup_addr_data",
              {PADDR, PWDATA}, {cur.addr, cur.wdata});
        check({PWRITE, PSTRB, PPROT, PNSE} ==
              {cur.write, (cur.write ? cur.strb : SW'(0)), cur.prot, cur.pnse},
              "setup_ctrl", 64'({PWRITE, PSTRB, PPROT, PNSE}),
              64'({cur.write, (cur.write ? cur.strb : SW'(0)), cur.prot, cur.pnse}));
      end
    end else if (|PSELx && PENABLE && active) begin
      k = sel_of(cur.addr);
      check(PSELx == (NS'(1) << k) && PADDR == cur.addr && PWDATA == cur.wdata &&
            PSTRB == (cur.write ? cur.strb : SW'(0)), "access_stable",
            {PADDR, PWDATA}, {cur.addr, cur.wdata});
      if (nacc >= cur.waits) begin
        rdy[k] = 1'b1;
        err[k] = cur.slverr;
        rd[k*DW +: DW] = cur.rval;
      end else begin
        rdy[k] = 1'b0;
      end
      nacc++;
    end
    PREADY = rdy;
    PSLVERR = err;
    PRDATA = rd;
  end

  // Completion monitor.
  initial forever begin
    exp_t e;
    @(negedge PCLK);
    if (!PRESET && done) begin
      if (exp_q.size() == 0) begin
        check(1'b0, "unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check(rdata == e.rdata, "rdata", 64'(rdata), 64'(e.rdata));
        check({error, timeout} == {e.error, e.tmo}, "error_timeout",
              64'({error, timeout}), 64'({e.error, e.tmo}));
        check(cyc == e.cycle, "done_cycle", 64'(cyc), 64'(e.cycle));
      end
    end else if (!done && (error || timeout)) begin
      check(1'b0, "flags_without_done", 64'({error, timeout}), 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge PCLK);
    #1;
    check(exp_q.size() == 0 && bus_q.size() == 0, "drain",
          64'(exp_q.size() + bus_q.size()), 0);
  endtask

  initial begin
    transfer = 0; write_en = 0; waddr = '0; wdata = '0; strb = '0; prot = '0; pnse = 0;
    repeat (3) @(negedge PCLK);
    #1;
    check({req_ready, done, rdata, error, timeout, PSELx, PENABLE, PADDR, PWRITE, PWDATA,
           PSTRB, PPROT, PNSE} == '0, "reset_outputs", 64'({done, PSELx, PENABLE}), 0);
    #2 PRESET = 0;
    @(posedge PCLK);
    #1;

    // Directed cases.
    send(mk(1, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 32'h0));
    idle(2);
    send(mk(0, 32'h8000_0020, 32'h0, 4'hF, 3, 0, 32'h1234_5678));
    idle(1);
    send(mk(1, 32'h0000_0004, 32'h1111_2222, 4'h3, 0, 0, 32'h0));
    send(mk(1, 32'h4000_0008, 32'h3333_4444, 4'hC, 0, 0, 32'h0));
    idle(2);
    send(mk(0, 32'h0000_0040, 32'h0, 4'h0, 40, 0, 32'hAAAA_5555));
    send(mk(0, 32'h4000_0044, 32'h0, 4'h0, TMO - 1, 0, 32'h5A5A_A5A5));
    idle(1);
    send(mk(1, 32'hC000_0000, 32'h9, 4'hF, 0, 0, 32'h0));
    send(mk(0, 32'h0000_0080, 32'h0, 4'h0, 1, 1, 32'hCAFE_F00D));
    drain();

    // Asynchronous reset during a waited read.
    send(mk(0, 32'h0000_0100, 32'h0, 4'h0, 10, 0, 32'h7777_7777));
    repeat (4) @(negedge PCLK);
    #1;
    check(PENABLE == 1'b1, "pre_reset_access", 64'(PENABLE), 1);
    #2 PRESET = 1;
    #1;
    check(PSELx == '0 && PENABLE == 1'b0 && req_ready == 1'b0, "reset_async",
          64'({PSELx, PENABLE, req_ready}), 0);
    exp_q.delete();
    bus_q.delete();
    repeat (2) @(negedge PCLK);
    #3 PRESET = 0;
    @(posedge PCLK);
    #1;
    send(mk(0, 32'h8000_0200, 32'h0, 4'h0, 0, 0, 32'h0BAD_CAFE));
    drain();

    // Randomised traffic with random gaps and wait states.
    for (int n = 0; n < 300; n++) begin
      int r, w;
      r = $urandom_range(0, 9);
      if (r < 6) w = $urandom_range(0, 2);
      else if (r < 9) w = $urandom_range(3, 6);
      else w = $urandom_range(TMO - 2, TMO + 2);
      send(mk(1'($urandom), $urandom, $urandom, SW'($urandom), w,
              ($urandom_range(0, 7) == 0), $urandom));
      idle($urandom_range(0, 2));
    end
    drain();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
